// File: rtl/serial_tx_shifter.sv
// serial_tx_shifter: parallel-in serial-out frame transmitter (start, data LSB first, optional parity, stop).
// Optional even-parity bit enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx_shifter #(
    parameter int WIDTH          = 8,
    parameter int CYCLES_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int CW = CYCLES_PER_BIT > 1 ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shift, shift_n;
    logic [CW-1:0]    cyc, cyc_n;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic             tx_n, done_n;
    logic             bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic             par, par_n;
`endif

    assign bit_end = cyc == CYC_LAST;
    assign ready   = state == IDLE;
    assign busy    = state != IDLE;

    // next-state logic; tx is derived from the next state so it is registered with no extra cycle of latency
    always_comb begin
        state_n = state;
        shift_n = shift;
        cyc_n   = bit_end ? '0 : cyc + 1'b1;
        bit_n   = bit_cnt;
        done_n  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                cyc_n = '0;
                bit_n = '0;
                if (load) begin
                    state_n = START;
                    shift_n = data_in;
`ifdef SERIAL_TX_PARITY_EN
                    par_n   = ^data_in;
`endif
                end
            end
            START: state_n = bit_end ? DATA : START;
            DATA: begin
                if (bit_end) begin
                    shift_n = shift >> 1;
                    bit_n   = bit_cnt == BIT_LAST ? '0 : bit_cnt + 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                    state_n = bit_cnt == BIT_LAST ? PARITY : DATA;
`else
                    state_n = bit_cnt == BIT_LAST ? STOP : DATA;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: state_n = bit_end ? STOP : PARITY;
`endif
            STOP: begin
                state_n = bit_end ? IDLE : STOP;
                done_n  = bit_end;
            end
            default: state_n = IDLE;
        endcase
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
`ifdef SERIAL_TX_PARITY_EN
        if (state_n == PARITY) tx_n = par_n;
`endif
    end

    // state, datapath and registered outputs; clr aborts any frame without a done pulse
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            shift   <= '0;
            cyc     <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
            done    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            cyc     <= cyc_n;
            bit_cnt <= bit_n;
            tx      <= tx_n;
            done    <= done_n;
`ifdef SERIAL_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end
endmodule

// File: doc/serial_tx_shifter.md
Name: serial_tx_shifter

Overview:
- Parallel-in, serial-out frame transmitter: the sending end of the bit-serial link whose receiving end is a sampling latch/shift register.
- Accepts one WIDTH-bit word per handshake and shifts it onto a single line: start bit, data LSB first, optional parity, stop bit.
- Each bit is held for CYCLES_PER_BIT clocks.
- Sits between the CPU's output register and an external serial line.

Parameters:
- WIDTH, 8, data bits per frame (>=1).
- CYCLES_PER_BIT, 4, clocks each bit is held on tx (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  synchronous, active-high reset; sampled on rising clk; dominates all other inputs.
- data_in  input  WIDTH  word to transmit; sampled only on an accepting edge.
- load  input  1  request to send data_in.
- ready  output  1  high when a load will be accepted this cycle.
- tx  output  1  serial line, registered; idle level 1.
- busy  output  1  high while a frame is in progress (START through STOP).
- done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset values (edge with clr=1): tx=1, ready=1, busy=0, done=0, state=IDLE, shift register=0, bit/cycle counters=0.
- clr=1 mid-frame aborts the frame at that edge with the same values; no done pulse.
- clr=1 together with load: the load is ignored.
- States and exits:
  - IDLE: tx=1, ready=1, busy=0. On load=1 at an edge, capture data_in into the shift register and go to START.
  - START: tx=0 for CYCLES_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0] for CYCLES_PER_BIT cycles per bit, then shift right. After WIDTH bits go to PARITY (if enabled) or STOP.
  - PARITY: tx=parity bit for CYCLES_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CYCLES_PER_BIT cycles, then IDLE with done=1 for exactly that first IDLE cycle.
- Latency: tx first goes 0 in the cycle right after the accepting edge.
- Frame length: (WIDTH+2)*CYCLES_PER_BIT cycles without parity, (WIDTH+3)*CYCLES_PER_BIT with parity. done rises exactly that many cycles after the accepting edge.
- ready = (state==IDLE). Asserted in the same cycle as done, so a load in that cycle is accepted and the next frame starts with no idle gap.
- load while busy: ignored, never queued. data_in changes while busy have no effect.
- Per-bit cycle counter counts 0..CYCLES_PER_BIT-1 and wraps at each bit boundary. CYCLES_PER_BIT=1 yields one clock per bit with no stall.
- Bit counter counts 0..WIDTH-1; the DATA->next transition happens on the last cycle of bit WIDTH-1.
- All outputs are registered; no combinational path from load or data_in to tx.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: PARITY state is present. Parity bit = XOR of the captured word (even parity: total count of 1s over data+parity is even). Computed at capture time, unaffected by later data_in changes.
- Undefined: no PARITY state; DATA goes directly to STOP. Frame length as above without parity.

Test Plan:
- Reset: clr=1 for 2 edges with load=1, data_in=8'hFF -> tx=1, ready=1, busy=0, done=0; no frame starts after clr drops while load=0.
- Basic frame, WIDTH=8, CYCLES_PER_BIT=2, no parity: load 8'hA5 -> tx holds 0, then 1,0,1,0,0,1,0,1, then 1, each for 2 cycles. busy=1 for 20 cycles; done pulses 20 cycles after accept.
- Parity, SERIAL_TX_PARITY_EN defined, same params: load 8'hA5 -> parity bit 0 after data, frame 22 cycles. load 8'h07 -> parity bit 1.
- Back-to-back: load held high with 8'h01 then 8'h80 presented in the done cycle -> second start bit begins the cycle after done, no idle gap. Load pulses during the first frame are ignored.
- Abort: clr=1 on cycle 7 of an 8'h3C frame -> tx=1, ready=1 on the next cycle, no done pulse. A new load of 8'hC3 then produces a complete, correct frame.
- CYCLES_PER_BIT=1, WIDTH=4: load 4'b1001 -> tx sequence 0,1,0,0,1,1 on consecutive cycles; done at cycle 6.
